// File: rtl/axi_dw_upsizer.sv
// rtl/axi_dw_upsizer.sv - AXI4 narrow-to-wide data width converter by lane steering
// One outstanding write and one outstanding read; AW/AR pass through, W/R steered by address offset.
module axi_dw_upsizer #(
  parameter int unsigned ADDR_WIDTH    = 64,
  parameter int unsigned SI_DATA_WIDTH = 32,
  parameter int unsigned MI_DATA_WIDTH = 256,
  parameter int unsigned ID_WIDTH      = 4,
  parameter int unsigned USER_WIDTH    = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  // slave port AW
  input  logic [ID_WIDTH-1:0]        slv_aw_id_i,
  input  logic [ADDR_WIDTH-1:0]      slv_aw_addr_i,
  input  logic [7:0]                 slv_aw_len_i,
  input  logic [2:0]                 slv_aw_size_i,
  input  logic [1:0]                 slv_aw_burst_i,
  input  logic                       slv_aw_lock_i,
  input  logic [3:0]                 slv_aw_cache_i,
  input  logic [2:0]                 slv_aw_prot_i,
  input  logic [3:0]                 slv_aw_qos_i,
  input  logic [3:0]                 slv_aw_region_i,
  input  logic [5:0]                 slv_aw_atop_i,
  input  logic [USER_WIDTH-1:0]      slv_aw_user_i,
  input  logic                       slv_aw_valid_i,
  output logic                       slv_aw_ready_o,
  // slave port W
  input  logic [SI_DATA_WIDTH-1:0]   slv_w_data_i,
  input  logic [SI_DATA_WIDTH/8-1:0] slv_w_strb_i,
  input  logic                       slv_w_last_i,
  input  logic [USER_WIDTH-1:0]      slv_w_user_i,
  input  logic                       slv_w_valid_i,
  output logic                       slv_w_ready_o,
  // slave port B
  output logic [ID_WIDTH-1:0]        slv_b_id_o,
  output logic [1:0]                 slv_b_resp_o,
  output logic [USER_WIDTH-1:0]      slv_b_user_o,
  output logic                       slv_b_valid_o,
  input  logic                       slv_b_ready_i,
  // slave port AR
  input  logic [ID_WIDTH-1:0]        slv_ar_id_i,
  input  logic [ADDR_WIDTH-1:0]      slv_ar_addr_i,
  input  logic [7:0]                 slv_ar_len_i,
  input  logic [2:0]                 slv_ar_size_i,
  input  logic [1:0]                 slv_ar_burst_i,
  input  logic                       slv_ar_lock_i,
  input  logic [3:0]                 slv_ar_cache_i,
  input  logic [2:0]                 slv_ar_prot_i,
  input  logic [3:0]                 slv_ar_qos_i,
  input  logic [3:0]                 slv_ar_region_i,
  input  logic [USER_WIDTH-1:0]      slv_ar_user_i,
  input  logic                       slv_ar_valid_i,
  output logic                       slv_ar_ready_o,
  // slave port R
  output logic [ID_WIDTH-1:0]        slv_r_id_o,
  output logic [SI_DATA_WIDTH-1:0]   slv_r_data_o,
  output logic [1:0]                 slv_r_resp_o,
  output logic                       slv_r_last_o,
  output logic [USER_WIDTH-1:0]      slv_r_user_o,
  output logic                       slv_r_valid_o,
  input  logic                       slv_r_ready_i,
  // master port AW
  output logic [ID_WIDTH-1:0]        mst_aw_id_o,
  output logic [ADDR_WIDTH-1:0]      mst_aw_addr_o,
  output logic [7:0]                 mst_aw_len_o,
  output logic [2:0]                 mst_aw_size_o,
  output logic [1:0]                 mst_aw_burst_o,
  output logic                       mst_aw_lock_o,
  output logic [3:0]                 mst_aw_cache_o,
  output logic [2:0]                 mst_aw_prot_o,
  output logic [3:0]                 mst_aw_qos_o,
  output logic [3:0]                 mst_aw_region_o,
  output logic [5:0]                 mst_aw_atop_o,
  output logic [USER_WIDTH-1:0]      mst_aw_user_o,
  output logic                       mst_aw_valid_o,
  input  logic                       mst_aw_ready_i,
  // master port W
  output logic [MI_DATA_WIDTH-1:0]   mst_w_data_o,
  output logic [MI_DATA_WIDTH/8-1:0] mst_w_strb_o,
  output logic                       mst_w_last_o,
  output logic [USER_WIDTH-1:0]      mst_w_user_o,
  output logic                       mst_w_valid_o,
  input  logic                       mst_w_ready_i,
  // master port B
  input  logic [ID_WIDTH-1:0]        mst_b_id_i,
  input  logic [1:0]                 mst_b_resp_i,
  input  logic [USER_WIDTH-1:0]      mst_b_user_i,
  input  logic                       mst_b_valid_i,
  output logic                       mst_b_ready_o,
  // master port AR
  output logic [ID_WIDTH-1:0]        mst_ar_id_o,
  output logic [ADDR_WIDTH-1:0]      mst_ar_addr_o,
  output logic [7:0]                 mst_ar_len_o,
  output logic [2:0]                 mst_ar_size_o,
  output logic [1:0]                 mst_ar_burst_o,
  output logic                       mst_ar_lock_o,
  output logic [3:0]                 mst_ar_cache_o,
  output logic [2:0]                 mst_ar_prot_o,
  output logic [3:0]                 mst_ar_qos_o,
  output logic [3:0]                 mst_ar_region_o,
  output logic [USER_WIDTH-1:0]      mst_ar_user_o,
  output logic                       mst_ar_valid_o,
  input  logic                       mst_ar_ready_i,
  // master port R
  input  logic [ID_WIDTH-1:0]        mst_r_id_i,
  input  logic [MI_DATA_WIDTH-1:0]   mst_r_data_i,
  input  logic [1:0]                 mst_r_resp_i,
  input  logic                       mst_r_last_i,
  input  logic [USER_WIDTH-1:0]      mst_r_user_i,
  input  logic                       mst_r_valid_i,
  output logic                       mst_r_ready_o
);

  localparam int unsigned SI_BYTES = SI_DATA_WIDTH / 8;
  localparam int unsigned MI_BYTES = MI_DATA_WIDTH / 8;
  localparam int unsigned SI_OFF   = $clog2(SI_BYTES);
  localparam int unsigned MI_OFF   = $clog2(MI_BYTES);
  localparam int unsigned LANE     = MI_OFF - SI_OFF;
  localparam int unsigned NLANES   = MI_BYTES / SI_BYTES;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

  w_state_e    w_state_q;
  r_state_e    r_state_q;
  logic [11:0] w_off_q, w_off_d, r_off_q, r_off_d;
  logic [2:0]  w_size_q, r_size_q;
  logic [7:0]  w_len_q, r_len_q;
  logic [1:0]  w_burst_q, r_burst_q;
  logic [LANE-1:0] w_lane, r_lane;

  // Offset is 12 bits so INCR naturally wraps at the 4 KiB boundary.
  function automatic logic [11:0] next_off(input logic [11:0] off, input logic [2:0] size,
                                           input logic [7:0] len, input logic [1:0] burst);
    logic [11:0] step;
    logic [11:0] bnd;
    step = 12'd1 << size;
    bnd  = ({4'd0, len} + 12'd1) << size;
    case (burst)
      2'b00:   return off;
      2'b10:   return (off & ~(bnd - 12'd1)) | ((off + step) & (bnd - 12'd1));
      default: return (off & ~(step - 12'd1)) + step;
    endcase
  endfunction

  assign w_off_d = next_off(w_off_q, w_size_q, w_len_q, w_burst_q);
  assign r_off_d = next_off(r_off_q, r_size_q, r_len_q, r_burst_q);
  assign w_lane  = w_off_q[MI_OFF-1:SI_OFF];
  assign r_lane  = r_off_q[MI_OFF-1:SI_OFF];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      w_state_q <= W_IDLE;
      w_off_q   <= '0;
      w_size_q  <= '0;
      w_len_q   <= '0;
      w_burst_q <= '0;
    end else begin
      case (w_state_q)
        W_IDLE: if (slv_aw_valid_i && mst_aw_ready_i) begin
          w_off_q   <= slv_aw_addr_i[11:0];
          w_size_q  <= slv_aw_size_i;
          w_len_q   <= slv_aw_len_i;
          w_burst_q <= slv_aw_burst_i;
          w_state_q <= W_DATA;
        end
        W_DATA: if (slv_w_valid_i && mst_w_ready_i) begin
          w_off_q <= w_off_d;
          if (slv_w_last_i) w_state_q <= W_RESP;
        end
        W_RESP: if (mst_b_valid_i && slv_b_ready_i) w_state_q <= W_IDLE;
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state_q <= R_IDLE;
      r_off_q   <= '0;
      r_size_q  <= '0;
      r_len_q   <= '0;
      r_burst_q <= '0;
    end else begin
      case (r_state_q)
        R_IDLE: if (slv_ar_valid_i && mst_ar_ready_i) begin
          r_off_q   <= slv_ar_addr_i[11:0];
          r_size_q  <= slv_ar_size_i;
          r_len_q   <= slv_ar_len_i;
          r_burst_q <= slv_ar_burst_i;
          r_state_q <= R_DATA;
        end
        R_DATA: if (mst_r_valid_i && slv_r_ready_i) begin
          r_off_q <= r_off_d;
          if (mst_r_last_i) r_state_q <= R_IDLE;
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  assign mst_aw_id_o     = slv_aw_id_i;
  assign mst_aw_addr_o   = slv_aw_addr_i;
  assign mst_aw_len_o    = slv_aw_len_i;
  assign mst_aw_size_o   = slv_aw_size_i;
  assign mst_aw_burst_o  = slv_aw_burst_i;
  assign mst_aw_lock_o   = slv_aw_lock_i;
  assign mst_aw_cache_o  = slv_aw_cache_i;
  assign mst_aw_prot_o   = slv_aw_prot_i;
  assign mst_aw_qos_o    = slv_aw_qos_i;
  assign mst_aw_region_o = slv_aw_region_i;
  assign mst_aw_atop_o   = slv_aw_atop_i;
  assign mst_aw_user_o   = slv_aw_user_i;
  assign mst_aw_valid_o  = slv_aw_valid_i && (w_state_q == W_IDLE);
  assign slv_aw_ready_o  = mst_aw_ready_i && (w_state_q == W_IDLE);

  assign mst_ar_id_o     = slv_ar_id_i;
  assign mst_ar_addr_o   = slv_ar_addr_i;
  assign mst_ar_len_o    = slv_ar_len_i;
  assign mst_ar_size_o   = slv_ar_size_i;
  assign mst_ar_burst_o  = slv_ar_burst_i;
  assign mst_ar_lock_o   = slv_ar_lock_i;
  assign mst_ar_cache_o  = slv_ar_cache_i;
  assign mst_ar_prot_o   = slv_ar_prot_i;
  assign mst_ar_qos_o    = slv_ar_qos_i;
  assign mst_ar_region_o = slv_ar_region_i;
  assign mst_ar_user_o   = slv_ar_user_i;
  assign mst_ar_valid_o  = slv_ar_valid_i && (r_state_q == R_IDLE);
  assign slv_ar_ready_o  = mst_ar_ready_i && (r_state_q == R_IDLE);

  // Data is replicated to every lane; only the strobe selects the target lane.
  assign mst_w_data_o  = {NLANES{slv_w_data_i}};
  assign mst_w_last_o  = slv_w_last_i;
  assign mst_w_user_o  = slv_w_user_i;
  assign mst_w_valid_o = slv_w_valid_i && (w_state_q == W_DATA);
  assign slv_w_ready_o = mst_w_ready_i && (w_state_q == W_DATA);

  always_comb begin
    mst_w_strb_o = '0;
    for (int i = 0; i < NLANES; i++) begin
      if (w_lane == LANE'(i)) mst_w_strb_o[i*SI_BYTES +: SI_BYTES] = slv_w_strb_i;
    end
  end

  assign slv_b_id_o    = mst_b_id_i;
  assign slv_b_resp_o  = mst_b_resp_i;
  assign slv_b_user_o  = mst_b_user_i;
  assign slv_b_valid_o = mst_b_valid_i && (w_state_q == W_RESP);
  assign mst_b_ready_o = slv_b_ready_i && (w_state_q == W_RESP);

  logic [SI_DATA_WIDTH-1:0] r_lanes [NLANES];
  for (genvar g = 0; g < NLANES; g++) begin : g_rlane
    assign r_lanes[g] = mst_r_data_i[g*SI_DATA_WIDTH +: SI_DATA_WIDTH];
  end

  assign slv_r_data_o  = r_lanes[r_lane];
  assign slv_r_id_o    = mst_r_id_i;
  assign slv_r_resp_o  = mst_r_resp_i;
  assign slv_r_last_o  = mst_r_last_i;
  assign slv_r_user_o  = mst_r_user_i;
  assign slv_r_valid_o = mst_r_valid_i && (r_state_q == R_DATA);
  assign mst_r_ready_o = slv_r_ready_i && (r_state_q == R_DATA);

endmodule

// File: doc/axi_dw_upsizer.md
# axi_dw_upsizer

Converts a narrow AXI4 slave port (SI_DATA_WIDTH) into a wide AXI4 master port (MI_DATA_WIDTH) by lane steering. Bursts are not merged: AW and AR pass through unchanged as narrow transfers, which are legal on the wide bus. Each W beat is placed on the correct wide byte lanes, and each R beat is extracted from the correct lanes. The block is the counterpart of the downsizing data width converter and sits between a narrow initiator and a wide interconnect or memory. It supports one outstanding write and one outstanding read, and the two directions are independent.

## Interface
- ADDR_WIDTH, 64: address width, both ports
- SI_DATA_WIDTH, 32: slave-port data width, power of 2, ≥8
- MI_DATA_WIDTH, 256: master-port data width, power of 2, > SI_DATA_WIDTH
- ID_WIDTH, 4: ID width, both ports
- USER_WIDTH, 8: user width, both ports
- clk_i  input  1  clock; all state on rising edge
- rst_ni  input  1  asynchronous active-low reset
- slv  AXI_BUS.Slave  SI_DATA_WIDTH  narrow port; the upstream initiator connects here
- mst  AXI_BUS.Master  MI_DATA_WIDTH  wide port; the downstream responder connects here

## Operation
- Derived constants:
  - SI_BYTES = SI_DATA_WIDTH/8, MI_BYTES = MI_DATA_WIDTH/8
  - LANE = log2(MI_BYTES) - log2(SI_BYTES)
  - lane index = offset[log2(MI_BYTES)-1 : log2(SI_BYTES)]
- Write FSM states: W_IDLE, W_DATA, W_RESP.
  - W_IDLE: mst.aw_valid = slv.aw_valid and slv.aw_ready = mst.aw_ready. All AW fields are forwarded unchanged. On the handshake, register offset = aw_addr[11:0], size, len and burst, then go to W_DATA.
  - W_DATA: W is forwarded.
    - mst.w_data = slv.w_data replicated MI/SI times.
    - mst.w_strb = slv.w_strb shifted to the current lane; all other lanes are 0.
    - w_last and w_user pass through.
    - Each W handshake advances offset. The handshake with w_last goes to W_RESP.
  - W_RESP: B passes through combinationally. The B handshake returns the FSM to W_IDLE.
- Read FSM states: R_IDLE, R_DATA.
  - R_IDLE: AR is forwarded exactly as AW is in W_IDLE. On the handshake, register offset, size, len and burst, then go to R_DATA.
  - R_DATA: slv.r_data = current lane slice of mst.r_data. id, resp, last and user pass through. Each R handshake advances offset. The handshake with r_last returns to R_IDLE.
- Offset advance, with step = 1<<size:
  - FIXED: offset unchanged.
  - INCR: offset = (offset & ~(step-1)) + step, using the 12-bit offset, which wraps at 4 KiB.
  - WRAP: boundary = (len+1)*step; offset = (offset & ~(boundary-1)) | ((offset+step) & (boundary-1)).
- Outside the DATA/RESP states, the W, R and B channels are gated:
  - slv.w_ready = 0 and mst.w_valid = 0 outside W_DATA.
  - slv.r_valid = 0 and mst.r_ready = 0 outside R_DATA.
  - slv.b_valid = 0 and mst.b_ready = 0 outside W_RESP.
- W arriving before AW is held; AW acceptance never depends on W.
- aw_atop must be 0; ATOPs are not supported and their behaviour is undefined. A size greater than log2(SI_BYTES) is illegal upstream and is not checked.

## Timing
- Reset: both FSMs go to IDLE and offset/size/len/burst go to 0 immediately (asynchronous). With both FSMs in IDLE, all W/R/B valids and readies are 0; AW/AR follow the combinational pass-through.
- Latency: zero cycles on every channel; all paths are combinational pass-through with lane muxing. Throughput is one beat per cycle.
- Back-to-back transactions:
  - A new AW is accepted no earlier than the cycle after the B handshake.
  - A new AR is accepted no earlier than the cycle after the r_last handshake.
  - AW/AR are stalled (ready = 0) while the FSM is not IDLE.
- Simultaneous events:
  - AW and AR handshakes in the same cycle are both accepted.
  - A W handshake and an R handshake in the same cycle each advance their own offset.
- Reset mid-burst: in-flight transactions are dropped. Both ports must be reset together.
- The valid/ready rules on both ports follow AXI4: valid is not retracted and payload is stable until the handshake. The block never creates a valid without the corresponding upstream valid.

## Test plan
All scenarios use SI=32, MI=256.
- Single write: addr 0x1C, size 2, len 0, data 0xDEADBEEF, strb 0xF → mst AW identical to slv AW; w_strb=0xF000_0000; w_data[255:224]=0xDEADBEEF; slv B carries the same id with OKAY.
- INCR write: addr 0x18, size 2, len 3 → lanes 6,7,0,1; w_strb 0x0F00_0000, 0xF000_0000, 0x0000_000F, 0x0000_00F0; w_last on beat 4 only.
- WRAP read: addr 0x38, size 2, len 3 → offsets 0x38, 0x3C, 0x30, 0x34, so lanes 6,7,4,5. slv.r_data equals mst.r_data[223:192], [255:224], [159:128], [191:160] in turn.
- Narrow INCR write: addr 0x03, size 0, len 4 → offsets 3,4,5,6,7, so lanes 0,1,1,1,1. Narrow strb bits appear at the same byte within each lane.
- FIXED read (addr 0x08, len 2) with an AR accepted concurrently with an AW write → every R beat is taken from lane 2 and both transactions complete independently.
- Reset at W beat 2 of an INCR len-7 burst → all valids/readies drop without waiting for a clock edge. After release, a new AW at addr 0x00 passes and lands on lane 0.
